// File: rtl/matrix_pkg.sv
// Shared types and sizes for the packed-matrix datapath.
// Used by the adder, the result streamer and the loader.
package matrix_pkg;
  localparam int DIM      = 5;
  localparam int ELEM_W   = 8;
  localparam int MAT_W    = DIM * DIM * ELEM_W;
  localparam int IDX_W    = $clog2(DIM);
  localparam int NUM_ELEM = DIM * DIM;
  localparam int K_W      = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker over a DIM x DIM matrix.
// Wraps back to (0,0) after the last element.
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] MAX = IDX_W'(DIM - 1);

  assign last = (row == MAX) && (col == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == MAX) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a packed result matrix on start and streams it
// element by element over valid/ready, tagged with row/col.
module matrix_result_streamer
  import matrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [MAT_W-1:0]         matrix_in,
  input  logic                     overflow_in,
  output logic                     busy,
  output logic                     elem_valid,
  input  logic                     elem_ready,
  output logic signed [ELEM_W-1:0] elem_data,
  output logic [IDX_W-1:0]         elem_row,
  output logic [IDX_W-1:0]         elem_col,
  output logic                     elem_last,
  output logic                     done,
  output logic                     overflow_out
);

  state_t           state;
  state_t           state_next;
  logic [MAT_W-1:0] shadow;
  logic             capture;
  logic             transfer;
  logic             cnt_last;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic [K_W-1:0]   k;

  assign capture  = (state == IDLE) && start;
  assign transfer = elem_valid && elem_ready;

  matrix_index_counter u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (capture),
    .en    (transfer),
    .row   (row),
    .col   (col),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      overflow_out <= 1'b0;
    end else if (capture) begin
      shadow       <= matrix_in;
      overflow_out <= overflow_in;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    elem_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        elem_valid = 1'b1;
        if (elem_ready && cnt_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flat index from counters: a multiply by a constant, no divider.
  assign k = K_W'(row) * K_W'(DIM) + K_W'(col);

  assign elem_data = elem_valid ? shadow[k*ELEM_W +: ELEM_W] : '0;
  assign elem_row  = elem_valid ? row : '0;
  assign elem_col  = elem_valid ? col : '0;
  assign elem_last = elem_valid && cnt_last;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed self-checking bench for matrix_result_streamer.
// One task per scenario, inline comparisons.
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [MAT_W-1:0]         matrix_in;
  logic                     overflow_in;
  logic                     busy;
  logic                     elem_valid;
  logic                     elem_ready;
  logic signed [ELEM_W-1:0] elem_data;
  logic [IDX_W-1:0]         elem_row;
  logic [IDX_W-1:0]         elem_col;
  logic                     elem_last;
  logic                     done;
  logic                     overflow_out;

  int tests;
  int fails;

  matrix_result_streamer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .matrix_in    (matrix_in),
    .overflow_in  (overflow_in),
    .busy         (busy),
    .elem_valid   (elem_valid),
    .elem_ready   (elem_ready),
    .elem_data    (elem_data),
    .elem_row     (elem_row),
    .elem_col     (elem_col),
    .elem_last    (elem_last),
    .done         (done),
    .overflow_out (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ELEM_W-1:0] ref_elem(
    input logic [MAT_W-1:0] m, input int k);
    return m[k*ELEM_W +: ELEM_W];
  endfunction

  function automatic logic [MAT_W-1:0] ramp(input int mul, input int add);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_ELEM; i++)
      m[i*ELEM_W +: ELEM_W] = ELEM_W'(i * mul + add);
    return m;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    elem_ready = 1'b0;
    matrix_in = '0;
    overflow_in = 1'b0;
    repeat (2) tick;
    tests++;
    if (busy !== 1'b0 || elem_valid !== 1'b0 || done !== 1'b0 ||
        overflow_out !== 1'b0)
      begin
      fails++;
      $display("FAIL reset_init: busy=%b valid=%b done=%b ovf=%b want 0",
               busy, elem_valid, done, overflow_out);
    end
    rst_n = 1'b1;
    tick;
    matrix_in = ramp(1, 5);
    overflow_in = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #3;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || elem_valid !== 1'b0 || elem_data !== 8'sd0 ||
        elem_row !== '0 || elem_col !== '0 || elem_last !== 1'b0 ||
        done !== 1'b0 || overflow_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: busy=%b valid=%b data=%0d r=%0d c=%0d last=%b done=%b ovf=%b want all 0",
               busy, elem_valid, elem_data, elem_row, elem_col,
               elem_last, done, overflow_out);
    end
    repeat (3) begin
      tick;
      tests++;
      if (busy !== 1'b0 || elem_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_start_held: busy=%b valid=%b want 0",
                 busy, elem_valid);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick;
    tests++;
    if (busy !== 1'b0 || elem_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: busy=%b valid=%b want 0",
               busy, elem_valid);
    end
  endtask

  task automatic test_full_stream;
    logic [7:0] a_list [25];
    logic [MAT_W-1:0] m;
    int exp;
    a_list = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3,
               8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
               8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12,
               8'd13, 8'd14};
    m = '0;
    for (int i = 0; i < 25; i++)
      m[(24-i)*ELEM_W +: ELEM_W] = a_list[i] + a_list[i];
    matrix_in = m;
    overflow_in = 1'b0;
    elem_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      exp = 2 * ((k <= 14) ? (14 - k) : (k - 14));
      tests++;
      if (elem_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          elem_data !== ELEM_W'(exp) ||
          elem_row !== IDX_W'(k / DIM) || elem_col !== IDX_W'(k % DIM) ||
          elem_last !== (k == 24)) begin
        fails++;
        $display("FAIL full_k%0d: valid=%b data=%0d r=%0d c=%0d last=%b want 1 %0d %0d %0d %b",
                 k, elem_valid, elem_data, elem_row, elem_col, elem_last,
                 exp, k / DIM, k % DIM, k == 24);
      end
      if (k == 0 || k == 10 || k == 24) begin
        tests++;
        if ((k == 0 && elem_data !== 8'sd28) ||
            (k == 10 && (elem_data !== 8'sd8 || elem_row !== 3'd2)) ||
            (k == 24 && (elem_data !== 8'sd20 || elem_last !== 1'b1))) begin
          fails++;
          $display("FAIL full_point_k%0d: data=%0d row=%0d last=%b",
                   k, elem_data, elem_row, elem_last);
        end
      end
      tick;
    end
    tests++;
    if (done !== 1'b1 || elem_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_done: done=%b valid=%b busy=%b want 1 0 1",
               done, elem_valid, busy);
    end
    tick;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL full_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_backpressure;
    logic [MAT_W-1:0] m;
    int k;
    int cyc;
    m = ramp(7, 3);
    matrix_in = m;
    elem_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 25 && cyc < 200) begin
      tests++;
      if (elem_valid !== 1'b1 || elem_data !== ref_elem(m, k) ||
          elem_row !== IDX_W'(k / DIM) || elem_col !== IDX_W'(k % DIM)) begin
        fails++;
        $display("FAIL bp_k%0d_c%0d: valid=%b data=%0d r=%0d c=%0d want 1 %0d %0d %0d",
                 k, cyc, elem_valid, elem_data, elem_row, elem_col,
                 $signed(ref_elem(m, k)), k / DIM, k % DIM);
      end
      if (k == 5) begin
        tests++;
        if (elem_row !== 3'd1 || elem_col !== 3'd0) begin
          fails++;
          $display("FAIL bp_k5_pos: r=%0d c=%0d want 1 0",
                   elem_row, elem_col);
        end
      end
      elem_ready = (cyc % 2 == 1);
      tick;
      if (elem_ready) k++;
      cyc++;
    end
    tests++;
    if (k != 25 || done !== 1'b1) begin
      fails++;
      $display("FAIL bp_done: transfers=%0d done=%b want 25 1", k, done);
    end
    elem_ready = 1'b1;
    tick;
  endtask

  task automatic test_start_while_busy;
    logic [MAT_W-1:0] m;
    int dones;
    m = ramp(3, 1);
    matrix_in = m;
    overflow_in = 1'b0;
    elem_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (elem_valid !== 1'b1 || elem_data !== ref_elem(m, k)) begin
        fails++;
        $display("FAIL swb_k%0d: valid=%b data=%0d want 1 %0d",
                 k, elem_valid, elem_data, $signed(ref_elem(m, k)));
      end
      start = (k == 7);
      if (k == 7) matrix_in = ~m;
      else if (k > 7) matrix_in = ~matrix_in;
      overflow_in = ~overflow_in;
      tick;
    end
    start = 1'b0;
    overflow_in = 1'b0;
    dones = 0;
    repeat (4) begin
      if (done === 1'b1) dones++;
      tick;
    end
    tests++;
    if (dones != 1 || busy !== 1'b0 || overflow_out !== 1'b0) begin
      fails++;
      $display("FAIL swb_end: dones=%0d busy=%b ovf=%b want 1 0 0",
               dones, busy, overflow_out);
    end
  endtask

  task automatic test_signed_overflow;
    logic [MAT_W-1:0] m;
    int n;
    m = ramp(1, 0);
    m[3*ELEM_W +: ELEM_W] = 8'h80;
    matrix_in = m;
    overflow_in = 1'b1;
    elem_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    overflow_in = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (overflow_out !== 1'b1 || elem_data !== ref_elem(m, k)) begin
        fails++;
        $display("FAIL so_k%0d: ovf=%b data=%0d want 1 %0d",
                 k, overflow_out, elem_data, $signed(ref_elem(m, k)));
      end
      if (k == 3) begin
        tests++;
        if (elem_data !== -128 || elem_row !== 3'd0 || elem_col !== 3'd3) begin
          fails++;
          $display("FAIL so_neg: data=%0d r=%0d c=%0d want -128 0 3",
                   elem_data, elem_row, elem_col);
        end
      end
      tick;
    end
    tests++;
    if (done !== 1'b1 || overflow_out !== 1'b1) begin
      fails++;
      $display("FAIL so_done: done=%b ovf=%b want 1 1", done, overflow_out);
    end
    tick;
    tick;
    tests++;
    if (busy !== 1'b0 || overflow_out !== 1'b1) begin
      fails++;
      $display("FAIL so_idle: busy=%b ovf=%b want 0 1", busy, overflow_out);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if (overflow_out !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL so_clear: ovf=%b busy=%b want 0 1", overflow_out, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    tests++;
    if (n != 25) begin
      fails++;
      $display("FAIL so_drain: cycles=%0d want 25", n);
    end
    tick;
  endtask

  task automatic test_reset_mid_stream;
    logic [MAT_W-1:0] m1;
    logic [MAT_W-1:0] m2;
    int dones;
    m1 = ramp(5, 2);
    m2 = ramp(11, 100);
    matrix_in = m1;
    elem_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (12) tick;
    tests++;
    if (elem_data !== ref_elem(m1, 12) || elem_row !== 3'd2) begin
      fails++;
      $display("FAIL rms_k12: data=%0d r=%0d want %0d 2",
               elem_data, elem_row, $signed(ref_elem(m1, 12)));
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (elem_valid !== 1'b0 || busy !== 1'b0 || elem_data !== 8'sd0 ||
        elem_row !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rms_abort: valid=%b busy=%b data=%0d r=%0d done=%b want 0",
               elem_valid, busy, elem_data, elem_row, done);
    end
    dones = 0;
    repeat (3) begin
      tick;
      if (done !== 1'b0) dones++;
    end
    rst_n = 1'b1;
    tick;
    if (done !== 1'b0) dones++;
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL rms_nodone: done pulses=%0d want 0", dones);
    end
    matrix_in = m2;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tests++;
      if (elem_valid !== 1'b1 || elem_data !== ref_elem(m2, k) ||
          elem_row !== IDX_W'(k / DIM) || elem_col !== IDX_W'(k % DIM)) begin
        fails++;
        $display("FAIL rms_k%0d: valid=%b data=%0d r=%0d c=%0d want 1 %0d %0d %0d",
                 k, elem_valid, elem_data, elem_row, elem_col,
                 $signed(ref_elem(m2, k)), k / DIM, k % DIM);
      end
      tick;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL rms_done: done=%b want 1", done);
    end
    tick;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_full_stream;
    test_backpressure;
    test_start_while_busy;
    test_signed_overflow;
    test_reset_mid_stream;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Reader side of the packed-matrix interface used by the matrix arithmetic units.
- On a start pulse, captures a packed DIM x DIM signed result matrix and its overflow flag, then streams the elements out one per transfer over a valid/ready handshake, tagged with row and column.
- Sits between the combinational matrix adder output and the downstream serial consumer, such as a UART/display formatter.

Parameters:
- DIM, 5, matrix dimension (rows = cols).
- ELEM_W, 8, element width in bits, signed two's complement.
- Derived locals: MAT_W = DIM*DIM*ELEM_W (200); IDX_W = $clog2(DIM) (3).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to capture matrix_in and begin streaming; honoured only when idle.
- matrix_in  input  MAT_W  packed matrix; element (r,c) at bits [(r*DIM+c)*ELEM_W +: ELEM_W].
- overflow_in  input  1  overflow flag accompanying matrix_in.
- busy  output  1  high from the capture cycle through the DONE cycle.
- elem_valid  output  1  elem_data, elem_row, elem_col and elem_last are valid.
- elem_ready  input  1  consumer accepts the element.
- elem_data  output  ELEM_W  signed element value.
- elem_row  output  IDX_W  row index, 0..DIM-1.
- elem_col  output  IDX_W  column index, 0..DIM-1.
- elem_last  output  1  high with element (DIM-1, DIM-1).
- done  output  1  one-cycle pulse after the last transfer.
- overflow_out  output  1  overflow flag latched at capture.

Behaviour:
- Reset (asynchronous, rst_n low): state goes to IDLE immediately. All outputs go to 0, including overflow_out. The shadow register and counters clear.
- FSM states: IDLE, STREAM, DONE.
- IDLE: when start=1, on that edge matrix_in goes to the shadow register, overflow_in goes to overflow_out, row and col go to 0, and the state goes to STREAM. busy and elem_valid are high from the next cycle; latency from start to first valid is 1 cycle.
- STREAM: elem_valid=1. Outputs come from the shadow register at index row*DIM+col. The index is formed from the row/col counters; no divider.
- Transfer: occurs when elem_valid && elem_ready. On a transfer, col increments. When col=DIM-1, col wraps to 0 and row increments.
- Backpressure: while elem_valid && !elem_ready, all element outputs hold stable.
- Throughput: 1 element per cycle when elem_ready is held high.
- elem_last = (row==DIM-1 && col==DIM-1) while in STREAM.
- A transfer with elem_last set moves the state to DONE.
- DONE: one cycle. elem_valid=0, done=1, busy=1. Next state is IDLE.
- start is ignored in STREAM and DONE. matrix_in and overflow_in changes after capture have no effect.
- overflow_out holds until the next accepted start; it does not clear in IDLE.
- Reset mid-stream: abort with no done pulse. The next start restarts at (0,0).
- elem_ready in IDLE or DONE is ignored.
- Arithmetic: no modification of values. elem_data is a bit-exact slice, signed.

Decomposition:
- Shared package matrix_pkg: DIM, ELEM_W, MAT_W, IDX_W, and the state encoding (IDLE=2'd0, STREAM=2'd1, DONE=2'd2).
- The same package is reused by the adder and the future matrix loader.
- One natural sub-module: matrix_index_counter (row/col counter with enable, wrap and last flag), also reusable by the loader.
- The element mux stays inline.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Hold start=1 during reset -> no capture.
2. Full stream, elem_ready=1: matrix_in = A+B for A=B={10,9,...,1,0,1,...,14} MSB-first; start pulse at cycle 0 ->
   - valid cycles 1..25, in order k=0..24;
   - k=0 (0,0)=28, k=10 (2,0)=8, k=24 (4,4)=20 with elem_last=1;
   - done=1 at cycle 26, busy=0 at cycle 27.
3. Backpressure: elem_ready alternating 0/1 -> each element is held until accepted, and 25 transfers complete in order. At k=5 the outputs read row=1, col=0. Nothing is skipped or duplicated (scoreboard against a reference slice).
4. Start while busy: pulse start at k=7 with a different matrix_in, and change matrix_in continuously -> stream continues from the captured data; a single done pulse.
5. Signed/overflow: element k=3 = 8'h80, overflow_in=1 at capture -> elem_data=-128 at (0,3). overflow_out=1 through DONE and in IDLE; it clears on the next start with overflow_in=0.
6. Reset mid-stream at k=12 -> outputs 0, no done pulse. The next start streams from (0,0) with the new matrix.
